ethernet_rx_slot_queue: RTL and testbench
=========================================

Name: ethernet_rx_slot_queue

Overview:
- Multi-slot receive descriptor queue with interrupt coalescing. It is the next-generation replacement for the single-packet receive handshake (packet_avail/packet_ack) and the fixed RX interrupt logic.
- Sits between the receive frame writer (AXIS side) and the memory-mapped register file.
- Holds up to slots_p received frames, in order, with per-slot size.
- Raises an RX interrupt when a frame-count threshold is reached or an age timeout expires.

Parameters:
- slots_p, 4: number of packet buffer slots; power of two, >= 2.
- eth_mtu_p, 2048: maximum frame size in bytes.
- timer_width_p, 16: width of the coalescing timer and timeout register.
- Derived: slot_id_w = $clog2(slots_p); size_w = $clog2(eth_mtu_p+1); cnt_w = $clog2(slots_p+1).

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  synchronous active-high reset
- wr_slot_o  out  slot_id_w  slot the writer must fill next
- wr_ready_o  out  1  at least one free slot
- frame_v_i  in  1  one-cycle pulse: frame in wr_slot_o complete
- frame_size_i  in  size_w  byte count of completed frame
- frame_good_i  in  1  frame passed FCS and framing checks
- rd_avail_o  out  1  queue non-empty
- rd_slot_o  out  slot_id_w  oldest committed slot
- rd_size_o  out  size_w  size of oldest committed frame
- ack_i  in  1  one-cycle pulse: software consumed head frame
- count_o  out  cnt_w  committed frame count
- cfg_v_i  in  1  configuration write strobe
- cfg_enable_i  in  1  interrupt enable
- cfg_threshold_i  in  cnt_w  coalescing frame threshold
- cfg_timeout_i  in  timer_width_p  coalescing timeout in cycles; 0 disables the timeout
- irq_pending_o  out  1  RX interrupt level

Behaviour:
- Reset values:
  - wr_ptr = rd_ptr = 0; count = 0; timer = 0.
  - enable = 0, threshold = 1, timeout = 0.
  - Outputs: wr_slot_o = 0, wr_ready_o = 1, rd_avail_o = 0, rd_slot_o = 0, rd_size_o = 0, count_o = 0, irq_pending_o = 0.
- Reset mid-operation discards all slots; no output depends on pre-reset state.
- Outputs are registered or driven directly from state: wr_ready_o = (count != slots_p); rd_avail_o = (count != 0).
- rd_size_o is read from the size flop array at rd_ptr.
- Commit: frame_v_i & frame_good_i & wr_ready_o & frame_size_i in [1, eth_mtu_p].
  - Stores the size at wr_ptr, increments wr_ptr (wraps modulo slots_p) and count.
  - The new frame is visible on rd_avail_o/count_o the next cycle.
- Any other frame_v_i is a drop: pointers unchanged, so the slot is reused. Drop causes: bad frame, zero size, size > eth_mtu_p, or queue full.
- Ack: ack_i & rd_avail_o increments rd_ptr (wraps) and decrements count. Ack when empty is ignored.
- Commit and ack in the same cycle: count unchanged, both pointers advance.
- A commit while count == slots_p is dropped even if ack_i is asserted in the same cycle. The full check uses the registered count.
- Config: on cfg_v_i, load enable, threshold and timeout.
  - A threshold of 0 is stored as 1.
  - A threshold > slots_p is stored as slots_p.
- Timer:
  - Cleared when count == 0 and on every ack.
  - Otherwise increments each cycle while below the timeout, and saturates at all-ones.
- Interrupt: irq_pending_o next-state = enable & ((count_next >= threshold) | (timeout != 0 & timer_next >= timeout)).
  - Interrupt latency is one cycle after the commit that reaches the threshold.
  - Deasserts one cycle after acks bring count below threshold and the timer condition is false.
- Disabling via cfg clears irq_pending_o on the next cycle; queue contents are unaffected.

Optional Feature:
- Macro: ETHERNET_RX_SLOT_QUEUE_STATS_EN.
- Enabled:
  - Adds outputs drop_full_count_o[31:0] and drop_bad_count_o[31:0], both saturating.
  - Queue-full drops increment drop_full_count_o. Bad-frame and size drops increment drop_bad_count_o.
  - Both counters reset to 0 and are cleared by a one-cycle stats_clear_i input.
- Disabled: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ethernet_pkg holds:
  - eth_mtu default;
  - size width function;
  - rx_cfg_s struct {enable, threshold, timeout}.
- One sub-module: ethernet_irq_coalescer (timer, threshold compare, pending register), driven by count_next and the ack pulse.

Test Plan:
- Reset, then 4 good frames of sizes 60, 1514, 64, 2048 → count_o = 4, wr_ready_o = 0, rd_size_o = 60; acks return 1514, 64, 2048 in order.
- 5th good frame while full, with ack_i in the same cycle → frame dropped, count_o = 3, drop_full_count_o = 1 (STATS_EN).
- Bad-FCS frame, zero-size frame, and 2049-byte frame → count_o stays 0, wr_slot_o unchanged, drop_bad_count_o = 3.
- cfg threshold = 3, enable = 1, timeout = 0; commit 2 frames → irq_pending_o = 0; 3rd frame → irq_pending_o = 1 the next cycle; one ack → 0 the next cycle.
- cfg threshold = 4, timeout = 100; commit 1 frame → irq_pending_o asserts exactly 100 cycles later; an ack at cycle 50 restarts the timer.
- Simultaneous commit and ack at count = 2, continued across 10 pointer wrap-arounds → count_o stays 2 and sizes are returned in FIFO order.

Source files
------------

// File: rtl/ethernet_pkg.sv
// Shared definitions for the Ethernet receive slot queue: defaults, width helper
// and the interrupt-coalescing configuration record.
package ethernet_pkg;

    localparam int eth_mtu_c     = 2048;
    localparam int cfg_cnt_w_c   = 16;
    localparam int cfg_timer_w_c = 32;

    function automatic int size_width(input int mtu);
        return $clog2(mtu + 1);
    endfunction

    // Fields are sized for the largest supported configuration and zero-extended on load.
    typedef struct packed {
        logic                     enable;
        logic [cfg_cnt_w_c-1:0]   threshold;
        logic [cfg_timer_w_c-1:0] timeout;
    } rx_cfg_s;

    localparam rx_cfg_s rx_cfg_reset_c = '{enable: 1'b0, threshold: 16'd1, timeout: 32'd0};

endpackage

// File: rtl/ethernet_irq_coalescer.sv
// RX interrupt coalescing: age timer since the queue became non-empty or was last
// acked, frame-count threshold compare and the registered pending level.
module ethernet_irq_coalescer
    import ethernet_pkg::*;
#(
    parameter int cnt_w         = 3,
    parameter int timer_width_p = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [cnt_w-1:0] count_i,
    input  logic [cnt_w-1:0] count_next_i,
    input  logic             ack_i,
    input  rx_cfg_s          cfg_i,
    output logic             irq_pending_o
);

    logic [timer_width_p-1:0] timer_q, timer_d;
    logic                     irq_q, irq_d;
    logic                     thr_hit, timeout_hit;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        timer_d = timer_q;
        if (count_i == '0 || ack_i) begin
            timer_d = '0;
        end else if (cfg_timer_w_c'(timer_q) < cfg_i.timeout && timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end

        thr_hit     = cfg_cnt_w_c'(count_next_i) >= cfg_i.threshold;
        timeout_hit = cfg_i.timeout != '0 && cfg_timer_w_c'(timer_d) >= cfg_i.timeout;
        irq_d       = cfg_i.enable && (thr_hit || timeout_hit);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            irq_q   <= irq_d;
        end
    end

    assign irq_pending_o = irq_q;

endmodule

// File: rtl/ethernet_rx_slot_queue.sv
// Multi-slot RX descriptor queue with interrupt coalescing.
// Optional drop statistics are built when ETHERNET_RX_SLOT_QUEUE_STATS_EN is defined.
module ethernet_rx_slot_queue
    import ethernet_pkg::*;
#(
    parameter  int slots_p       = 4,
    parameter  int eth_mtu_p     = eth_mtu_c,
    parameter  int timer_width_p = 16,
    localparam int slot_id_w     = $clog2(slots_p),
    localparam int size_w        = size_width(eth_mtu_p),
    localparam int cnt_w         = $clog2(slots_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic [slot_id_w-1:0]     wr_slot_o,
    output logic                     wr_ready_o,
    input  logic                     frame_v_i,
    input  logic [size_w-1:0]        frame_size_i,
    input  logic                     frame_good_i,
    output logic                     rd_avail_o,
    output logic [slot_id_w-1:0]     rd_slot_o,
    output logic [size_w-1:0]        rd_size_o,
    input  logic                     ack_i,
    output logic [cnt_w-1:0]         count_o,
    input  logic                     cfg_v_i,
    input  logic                     cfg_enable_i,
    input  logic [cnt_w-1:0]         cfg_threshold_i,
    input  logic [timer_width_p-1:0] cfg_timeout_i,
    output logic                     irq_pending_o
`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
    ,
    input  logic                     stats_clear_i,
    output logic [31:0]              drop_full_count_o,
    output logic [31:0]              drop_bad_count_o
`endif
);

    localparam logic [cnt_w-1:0]  slots_c = cnt_w'(slots_p);
    localparam logic [size_w-1:0] mtu_c   = size_w'(eth_mtu_p);

    logic [slot_id_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]     count_q, count_d;
    logic [size_w-1:0]    size_q [slots_p];
    rx_cfg_s              cfg_q, cfg_d;
    logic                 full, size_ok, commit, ack;

    // Full is judged on the registered count, so a same-cycle ack cannot admit a frame.
    assign full    = count_q == slots_c;
    assign size_ok = frame_size_i != '0 && frame_size_i <= mtu_c;
    assign commit  = frame_v_i && frame_good_i && size_ok && !full;
    assign ack     = ack_i && count_q != '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (commit) wr_ptr_d = wr_ptr_q + 1'b1;
        if (ack)    rd_ptr_d = rd_ptr_q + 1'b1;
        case ({commit, ack})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_v_i) begin
            cfg_d.enable  = cfg_enable_i;
            cfg_d.timeout = cfg_timer_w_c'(cfg_timeout_i);
            if (cfg_threshold_i == '0) begin
                cfg_d.threshold = 16'd1;
            end else if (cfg_threshold_i > slots_c) begin
                cfg_d.threshold = cfg_cnt_w_c'(slots_c);
            end else begin
                cfg_d.threshold = cfg_cnt_w_c'(cfg_threshold_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cfg_q    <= rx_cfg_reset_c;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cfg_q    <= cfg_d;
        end
    end

    // NOTE: the size array has no reset; an entry is only observable after a commit writes it.
    always_ff @(posedge clk_i) begin
        if (commit) size_q[wr_ptr_q] <= frame_size_i;
    end

    // The coalescer sees the new configuration in the cycle it is written.
    ethernet_irq_coalescer #(
        .cnt_w         (cnt_w),
        .timer_width_p (timer_width_p)
    ) u_coalescer (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .count_i       (count_q),
        .count_next_i  (count_d),
        .ack_i         (ack),
        .cfg_i         (cfg_d),
        .irq_pending_o (irq_pending_o)
    );

    assign wr_slot_o  = wr_ptr_q;
    assign wr_ready_o = !full;
    assign rd_avail_o = count_q != '0;
    assign rd_slot_o  = rd_ptr_q;
    assign rd_size_o  = rd_avail_o ? size_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
    logic [31:0] drop_full_q, drop_full_d, drop_bad_q, drop_bad_d;

    always_comb begin
        drop_full_d = drop_full_q;
        drop_bad_d  = drop_bad_q;
        if (stats_clear_i) begin
            drop_full_d = '0;
            drop_bad_d  = '0;
        end else if (frame_v_i) begin
            if (!frame_good_i || !size_ok) begin
                if (drop_bad_q != '1) drop_bad_d = drop_bad_q + 1'b1;
            end else if (full) begin
                if (drop_full_q != '1) drop_full_d = drop_full_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drop_full_q <= '0;
            drop_bad_q  <= '0;
        end else begin
            drop_full_q <= drop_full_d;
            drop_bad_q  <= drop_bad_d;
        end
    end

    assign drop_full_count_o = drop_full_q;
    assign drop_bad_count_o  = drop_bad_q;
`endif

endmodule

// File: tb/tb_ethernet_rx_slot_queue.sv
// Self-checking bench for ethernet_rx_slot_queue: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_ethernet_rx_slot_queue;

    localparam int SLOTS = 4;
    localparam int MTU   = 2048;
    localparam int TW    = 16;
    localparam int SIDW  = 2;
    localparam int SZW   = 12;
    localparam int CNTW  = 3;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic [SIDW-1:0] wr_slot_o, rd_slot_o;
    logic            wr_ready_o, rd_avail_o, irq_pending_o;
    logic            frame_v_i = 1'b0, frame_good_i = 1'b0, ack_i = 1'b0;
    logic [SZW-1:0]  frame_size_i = '0, rd_size_o;
    logic [CNTW-1:0] count_o;
    logic            cfg_v_i = 1'b0, cfg_enable_i = 1'b0;
    logic [CNTW-1:0] cfg_threshold_i = '0;
    logic [TW-1:0]   cfg_timeout_i = '0;
`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
    logic            stats_clear_i = 1'b0;
    logic [31:0]     drop_full_count_o, drop_bad_count_o;
`endif

    always #5 clk = ~clk;

    ethernet_rx_slot_queue #(.slots_p(SLOTS), .eth_mtu_p(MTU), .timer_width_p(TW)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .wr_slot_o       (wr_slot_o),
        .wr_ready_o      (wr_ready_o),
        .frame_v_i       (frame_v_i),
        .frame_size_i    (frame_size_i),
        .frame_good_i    (frame_good_i),
        .rd_avail_o      (rd_avail_o),
        .rd_slot_o       (rd_slot_o),
        .rd_size_o       (rd_size_o),
        .ack_i           (ack_i),
        .count_o         (count_o),
        .cfg_v_i         (cfg_v_i),
        .cfg_enable_i    (cfg_enable_i),
        .cfg_threshold_i (cfg_threshold_i),
        .cfg_timeout_i   (cfg_timeout_i),
        .irq_pending_o   (irq_pending_o)
`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
        ,
        .stats_clear_i     (stats_clear_i),
        .drop_full_count_o (drop_full_count_o),
        .drop_bad_count_o  (drop_bad_count_o)
`endif
    );

    // Reference model: committed sizes in arrival order double as the scoreboard.
    int  exp_q[$];
    int  wr_m, rd_m, timer_m, thr_m, to_m;
    bit  irq_m, en_m;
    longint dfull_m, dbad_m;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_update();
        int  old;
        bit  size_ok, commit, ackd;
        if (reset_i) begin
            exp_q.delete();
            wr_m = 0; rd_m = 0; timer_m = 0; irq_m = 0;
            en_m = 0; thr_m = 1; to_m = 0; dfull_m = 0; dbad_m = 0;
            return;
        end
        old     = exp_q.size();
        size_ok = frame_size_i >= 1 && frame_size_i <= MTU;
        commit  = frame_v_i && frame_good_i && size_ok && old < SLOTS;
        ackd    = ack_i && old > 0;
`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
        if (stats_clear_i) begin
            dfull_m = 0; dbad_m = 0;
        end else if (frame_v_i) begin
            if (!frame_good_i || !size_ok) dbad_m++;
            else if (old == SLOTS) dfull_m++;
        end
`endif
        if (cfg_v_i) begin
            en_m  = cfg_enable_i;
            to_m  = int'(cfg_timeout_i);
            thr_m = (cfg_threshold_i == 0) ? 1 : (cfg_threshold_i > SLOTS) ? SLOTS : int'(cfg_threshold_i);
        end
        if (ackd) begin
            void'(exp_q.pop_front());
            rd_m = (rd_m + 1) % SLOTS;
        end
        if (commit) begin
            exp_q.push_back(int'(frame_size_i));
            wr_m = (wr_m + 1) % SLOTS;
        end
        // Age counts cycles since the queue was found non-empty or last acked.
        if (old == 0 || ackd) timer_m = 0;
        else if (timer_m < to_m) timer_m++;
        irq_m = en_m && (exp_q.size() >= thr_m || (to_m != 0 && timer_m >= to_m));
    endfunction

    // Inputs change 1 ns after the active edge; the model advances on the edge itself.
    task automatic step(input bit fv = 0, input int sz = 0, input bit good = 1, input bit ack = 0);
        frame_v_i    = fv;
        frame_size_i = SZW'(sz);
        frame_good_i = good;
        ack_i        = ack;
        @(posedge clk);
        model_update();
        started = 1'b1;
        #1;
        frame_v_i = 1'b0;
        ack_i     = 1'b0;
        cfg_v_i   = 1'b0;
`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
        stats_clear_i = 1'b0;
`endif
    endtask

    task automatic cfg(input bit en, input int thr, input int to);
        cfg_v_i         = 1'b1;
        cfg_enable_i    = en;
        cfg_threshold_i = CNTW'(thr);
        cfg_timeout_i   = TW'(to);
        step();
    endtask

    // Monitor: compares every observable output against the model away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("wr_slot", 64'(wr_slot_o), 64'(wr_m));
            check("wr_ready", 64'(wr_ready_o), 64'(exp_q.size() != SLOTS));
            check("rd_avail", 64'(rd_avail_o), 64'(exp_q.size() != 0));
            check("rd_slot", 64'(rd_slot_o), 64'(rd_m));
            check("count", 64'(count_o), 64'(exp_q.size()));
            check("rd_size", 64'(rd_size_o), (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'd0);
            check("irq", 64'(irq_pending_o), 64'(irq_m));
`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
            check("drop_full", 64'(drop_full_count_o), 64'(dfull_m));
            check("drop_bad", 64'(drop_bad_count_o), 64'(dbad_m));
`endif
        end
    end

    initial begin
        int first;
        int sz;

        reset_i = 1'b1;
        repeat (3) step();
        reset_i = 1'b0;
        check("reset_wr_ready", 64'(wr_ready_o), 64'd1);
        check("reset_count", 64'(count_o), 64'd0);

        // Fill all slots.
        step(1, 60); step(1, 1514); step(1, 64); step(1, 2048);
        check("full_count", 64'(count_o), 64'd4);
        check("full_wr_ready", 64'(wr_ready_o), 64'd0);
        check("full_head_size", 64'(rd_size_o), 64'd60);

        // Commit while full with simultaneous ack is dropped.
        step(1, 100, 1, 1);
        check("full_drop_count", 64'(count_o), 64'd3);
`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
        check("full_drop_stat", 64'(drop_full_count_o), 64'd1);
`endif
        check("head_after_ack", 64'(rd_size_o), 64'd1514);
        repeat (3) step(0, 0, 1, 1);

        // Bad FCS, zero size, oversize.
        step(1, 100, 0); step(1, 0, 1); step(1, 2049, 1);
        check("bad_count", 64'(count_o), 64'd0);
        check("bad_wr_slot", 64'(wr_slot_o), 64'd0);
`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
        check("bad_stat", 64'(drop_bad_count_o), 64'd3);
`endif

        // Threshold coalescing.
        cfg(1, 3, 0);
        step(1, 200); step(1, 300);
        check("thr_below", 64'(irq_pending_o), 64'd0);
        step(1, 400);
        check("thr_reached", 64'(irq_pending_o), 64'd1);
        step(0, 0, 1, 1);
        check("thr_ack_clear", 64'(irq_pending_o), 64'd0);
        repeat (2) step(0, 0, 1, 1);

        // Timeout coalescing.
        cfg(1, 4, 100);
        step(1, 128);
        first = -1;
        for (int i = 1; i <= 150; i++) begin
            step();
            if (irq_pending_o && first < 0) first = i;
        end
        check("timeout_latency", 64'(first), 64'd100);
        step(0, 0, 1, 1);

        // Ack 50 cycles after the first commit restarts the age.
        step(1, 256); step(1, 512);
        repeat (48) step();
        step(0, 0, 1, 1);
        check("restart_irq_low", 64'(irq_pending_o), 64'd0);
        first = -1;
        for (int i = 1; i <= 150; i++) begin
            step();
            if (irq_pending_o && first < 0) first = i;
        end
        check("restart_latency", 64'(first), 64'd100);
        step(0, 0, 1, 1);

        // Steady commit+ack at depth 2 across many pointer wraps.
        cfg(0, 1, 0);
        step(1, 11); step(1, 22);
        for (int i = 0; i < 40; i++) step(1, int'($urandom_range(1, MTU)), 1, 1);
        check("wrap_count", 64'(count_o), 64'd2);

        // Disable clears the interrupt without touching the queue.
        cfg(1, 1, 0);
        check("enable_irq", 64'(irq_pending_o), 64'd1);
        cfg(0, 1, 0);
        check("disable_irq", 64'(irq_pending_o), 64'd0);
        check("disable_count", 64'(count_o), 64'd2);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 5) begin
                cfg_v_i         = 1'b1;
                cfg_enable_i    = 1'($urandom_range(0, 3) != 0);
                cfg_threshold_i = CNTW'($urandom_range(0, 7));
                cfg_timeout_i   = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 40));
            end
`ifdef ETHERNET_RX_SLOT_QUEUE_STATS_EN
            if ($urandom_range(0, 99) == 0) stats_clear_i = 1'b1;
`endif
            reset_i = ($urandom_range(0, 499) == 0);
            case ($urandom_range(0, 9))
                0:       sz = 0;
                1:       sz = MTU + int'($urandom_range(1, 50));
                2:       sz = MTU;
                3:       sz = 1;
                default: sz = int'($urandom_range(1, MTU));
            endcase
            step(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 9) < 4));
        end
        reset_i = 1'b0;
        step();
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
